irq_gen_mux_n: RTL and testbench
================================

IRQ_GEN_MUX_N -- requirements
Module: irq_gen_mux_n

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of source channels (1..16).
REQ-002 SHALL have parameter NOUT, default 2, meaning number of routed outputs (1..8).
REQ-003 SHALL have parameter DEB_CYCLES, default 4, meaning debounce stable-count threshold (1..255).
REQ-004 SHALL have port PCLK  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port PRESERN  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports PSEL, PENABLE, PWRITE  in  1 each  APB3 slave control.
REQ-007 SHALL have port PADDR  in  32  APB address; only PADDR[7:0] decoded.
REQ-008 SHALL have port PWDATA  in  32  APB write data.
REQ-009 SHALL have ports PREADY, PSLVERR  out  1 each  APB response.
REQ-010 SHALL have port PRDATA  out  32  APB read data.
REQ-011 SHALL have port src  in  NCH  asynchronous external sources (buttons, sensors).
REQ-012 SHALL have port out  out  NOUT  routed or software-driven outputs.
REQ-013 SHALL have port interrupt  out  1  level interrupt to processor fabric input.
REQ-014 SHALL have port debug_led  out  1  copy of interrupt.

Function
REQ-015 SHALL pass each src bit through a 2-flop synchronizer before any use.
REQ-016 SHALL per channel keep a filtered level that changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; counter resets on any match, saturates, never wraps.
REQ-017 SHALL per channel detect, from MODE (2 bits): 00 rising, 01 falling, 10 both edges, 11 level-high, on the filtered level.
REQ-018 SHALL set PENDING[i] one cycle after a detected event when CTRL.GEN=1; for level mode, PENDING[i] set every cycle the filtered level is 1.
REQ-019 SHALL drive interrupt = |(PENDING & ENABLE) registered, i.e. one cycle after PENDING update.
REQ-020 SHALL clear PENDING bits by writing 1 (W1C); a simultaneous set event in that cycle wins (bit stays 1).
REQ-021 SHALL increment 16-bit IRQ_COUNT once per cycle in which any PENDING bit transitions 0->1, saturating at 0xFFFF; any write clears it, and a simultaneous increment is lost.
REQ-022 SHALL drive out[k] = OUT_SW[k] when OUT_MODE[k]=1, else filtered level of channel OUT_ROUTE[4k+3:4k]; index >= NCH yields 0; out registered.
REQ-023 SHALL decode word offsets: 0x00 CTRL (bit0 GEN), 0x04 ENABLE, 0x08 PENDING (R/W1C), 0x0C STATUS filtered levels (RO), 0x10 MODE, 0x14 OUT_ROUTE, 0x18 OUT_MODE, 0x1C OUT_SW, 0x20 IRQ_COUNT (R, write clears).
REQ-024 SHALL perform writes in the access phase only (PSEL & PENABLE & PWRITE); bits beyond NCH/NOUT ignored and read as 0.
REQ-025 SHALL drive PREADY=1 always (zero wait states).
REQ-026 SHALL assert PSLVERR in the access phase for offsets above 0x20 or writes to 0x0C; such writes have no effect.
REQ-027 SHALL drive PRDATA combinationally from the addressed register when PSEL & !PWRITE, else 0.

Reset
REQ-028 SHALL on PRESERN=0 asynchronously clear all registers, synchronizers, debounce counters, filtered levels, PENDING, IRQ_COUNT; out=0, interrupt=0, debug_led=0, PSLVERR=0, PRDATA=0.
REQ-029 SHALL, when reset asserts mid APB transfer, abandon the transfer with no register update.
REQ-030 SHALL not generate an edge event from the post-reset filtered level (0) until a debounced change occurs.

Verification
REQ-031 SHALL cover: CTRL=1, ENABLE=0x1, MODE ch0=rising, src[0] 0->1 held 10 cycles -> PENDING=0x1 at sync(2)+DEB_CYCLES+1, interrupt=1 one cycle later.
REQ-032 SHALL cover: src[1] glitch high for DEB_CYCLES-1 cycles -> STATUS, PENDING unchanged (0).
REQ-033 SHALL cover: write 0x1 to PENDING in same cycle as new ch0 event -> PENDING[0] stays 1, IRQ_COUNT unchanged by set-on-already-set.
REQ-034 SHALL cover: OUT_ROUTE=0x0000_0032, OUT_MODE=0 -> out[0] follows ch2, out[1] follows ch3; OUT_MODE=0x2, OUT_SW=0x2 -> out[1]=1.
REQ-035 SHALL cover: read offset 0x24 -> PSLVERR=1, PRDATA=0; write 0x0C -> PSLVERR=1, STATUS unchanged.
REQ-036 SHALL cover: PRESERN low during access phase with interrupt=1 -> all outputs 0 immediately, registers read 0 after release.

Source files
------------

// File: rtl/irq_gen_mux_n.sv
`default_nettype none
// ============================================================================
// Module  : irq_gen_mux_n
// Brief   : APB3 interrupt generator with per-channel debounce, edge/level
//           detection, W1C pending bits, event counter and output routing.
// Rev     : 1.0
// ============================================================================
module irq_gen_mux_n #(
    parameter int NCH        = 4,
    parameter int NOUT       = 2,
    parameter int DEB_CYCLES = 4
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [31:0]      PRDATA,
    input  logic [NCH-1:0]   src,
    output logic [NOUT-1:0]  out,
    output logic             interrupt,
    output logic             debug_led
);

    localparam logic [5:0] c_W_CTRL   = 6'd0;
    localparam logic [5:0] c_W_EN     = 6'd1;
    localparam logic [5:0] c_W_PEND   = 6'd2;
    localparam logic [5:0] c_W_STAT   = 6'd3;
    localparam logic [5:0] c_W_MODE   = 6'd4;
    localparam logic [5:0] c_W_ROUTE  = 6'd5;
    localparam logic [5:0] c_W_OMODE  = 6'd6;
    localparam logic [5:0] c_W_OSW    = 6'd7;
    localparam logic [5:0] c_W_CNT    = 6'd8;
    localparam logic [7:0] c_DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [NCH-1:0]    r_sync1, r_sync2, r_filt_d;
    logic [NCH-1:0]    w_filt, w_evt, w_set, w_w1c, w_pend_nxt;
    logic              r_gen;
    logic [NCH-1:0]    r_en, r_pend;
    logic [2*NCH-1:0]  r_mode;
    logic [4*NOUT-1:0] r_route;
    logic [NOUT-1:0]   r_omode, r_osw, r_out, w_route_lvl, w_out;
    logic [15:0]       r_irq_cnt;
    logic              r_irq;
    logic [5:0]        w_word;
    logic              w_bad_addr, w_acc, w_err, w_we;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_word     = PADDR[7:2];
    assign w_bad_addr = PADDR[7:0] > 8'h20;
    assign w_acc      = PSEL & PENABLE;
    assign w_err      = w_acc & (w_bad_addr | (PWRITE & (w_word == c_W_STAT)));
    assign w_we       = w_acc & PWRITE & ~w_err;
    assign w_unused   = ^{PADDR[31:8], PWDATA};

    // Per-channel debounce: level flips only after DEB_CYCLES straight mismatches
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [7:0] r_cnt;
        logic       r_lvl;
        always_ff @(posedge PCLK or negedge PRESERN) begin
            if (!PRESERN) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[i] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                r_cnt <= '0;
                r_lvl <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
        assign w_filt[i] = r_lvl;
        assign w_evt[i]  = r_mode[2*i+1]
                         ? (r_mode[2*i] ? r_lvl : (r_lvl ^ r_filt_d[i]))
                         : (r_mode[2*i] ? (~r_lvl & r_filt_d[i]) : (r_lvl & ~r_filt_d[i]));
    end

    assign w_set      = r_gen ? w_evt : '0;
    assign w_w1c      = (w_we && (w_word == c_W_PEND)) ? PWDATA[NCH-1:0] : '0;
    assign w_pend_nxt = (r_pend & ~w_w1c) | w_set;

    always_comb begin
        w_route_lvl = '0;
        for (int k = 0; k < NOUT; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (r_route[4*k +: 4] == 4'(c))
                    w_route_lvl[k] = w_filt[c];
            end
        end
    end
    assign w_out = (r_omode & r_osw) | (~r_omode & w_route_lvl);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_filt_d  <= '0;
            r_gen     <= 1'b0;
            r_en      <= '0;
            r_pend    <= '0;
            r_mode    <= '0;
            r_route   <= '0;
            r_omode   <= '0;
            r_osw     <= '0;
            r_out     <= '0;
            r_irq_cnt <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_sync1  <= src;
            r_sync2  <= r_sync1;
            r_filt_d <= w_filt;
            r_pend   <= w_pend_nxt;
            r_irq    <= |(r_pend & r_en);
            r_out    <= w_out;
            if (w_we) begin
                case (w_word)
                    c_W_CTRL:  r_gen   <= PWDATA[0];
                    c_W_EN:    r_en    <= PWDATA[NCH-1:0];
                    c_W_MODE:  r_mode  <= PWDATA[2*NCH-1:0];
                    c_W_ROUTE: r_route <= PWDATA[4*NOUT-1:0];
                    c_W_OMODE: r_omode <= PWDATA[NOUT-1:0];
                    c_W_OSW:   r_osw   <= PWDATA[NOUT-1:0];
                    default:   ;
                endcase
            end
            // A clearing write beats a same-cycle increment
            if (w_we && (w_word == c_W_CNT))
                r_irq_cnt <= '0;
            else if (|(w_pend_nxt & ~r_pend) && (r_irq_cnt != 16'hFFFF))
                r_irq_cnt <= r_irq_cnt + 16'd1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_W_CTRL:  w_rdata[0]           = r_gen;
            c_W_EN:    w_rdata[NCH-1:0]     = r_en;
            c_W_PEND:  w_rdata[NCH-1:0]     = r_pend;
            c_W_STAT:  w_rdata[NCH-1:0]     = w_filt;
            c_W_MODE:  w_rdata[2*NCH-1:0]   = r_mode;
            c_W_ROUTE: w_rdata[4*NOUT-1:0]  = r_route;
            c_W_OMODE: w_rdata[NOUT-1:0]    = r_omode;
            c_W_OSW:   w_rdata[NOUT-1:0]    = r_osw;
            c_W_CNT:   w_rdata[15:0]        = r_irq_cnt;
            default:   w_rdata              = '0;
        endcase
        if (w_bad_addr)
            w_rdata = '0;
    end

    assign PREADY    = 1'b1;
    assign PSLVERR   = w_err & PRESERN;
    assign PRDATA    = (PSEL & ~PWRITE & PRESERN) ? w_rdata : '0;
    assign out       = r_out;
    assign interrupt = r_irq;
    assign debug_led = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_irq_gen_mux_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_irq_gen_mux_n
// Brief   : Scoreboard bench for irq_gen_mux_n (APB and pin expectations).
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_irq_gen_mux_n;
    localparam int NCH  = 4;
    localparam int NOUT = 2;
    localparam int DEB  = 4;

    logic             PCLK = 1'b0, PRESERN = 1'b0;
    logic             PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0]      PADDR = '0, PWDATA = '0;
    logic             PREADY, PSLVERR;
    logic [31:0]      PRDATA;
    logic [NCH-1:0]   src = '0;
    logic [NOUT-1:0]  out;
    logic             interrupt, debug_led;

    always #5 PCLK = ~PCLK;

    irq_gen_mux_n #(.NCH(NCH), .NOUT(NOUT), .DEB_CYCLES(DEB)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PRDATA(PRDATA), .src(src), .out(out),
        .interrupt(interrupt), .debug_led(debug_led)
    );

    typedef struct { string nm; logic [31:0] data; logic err; } apb_exp_t;
    typedef struct { string nm; int cyc; logic irq; logic [NOUT-1:0] outv; } pin_exp_t;

    apb_exp_t apb_q[$];
    pin_exp_t pin_q[$];
    apb_exp_t ae;
    pin_exp_t pe;
    int n_chk = 0, n_pass = 0, cyc = 0;
    int t0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
        n_chk++;
        if (act === ev) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ev);
    endtask

    // Monitor: pops APB expectations on each access phase, pin expectations by cycle
    always @(negedge PCLK) begin
        if (PRESERN && PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                ae = apb_q.pop_front();
                chk({ae.nm, "_prdata"}, PRDATA, ae.data);
                chk({ae.nm, "_pslverr"}, 32'(PSLVERR), 32'(ae.err));
                chk({ae.nm, "_pready"}, 32'(PREADY), 32'd1);
            end
        end
        while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
            pe = pin_q.pop_front();
            if (pe.cyc != cyc) begin
                chk({pe.nm, "_missed"}, 32'(cyc), 32'(pe.cyc));
            end else begin
                chk({pe.nm, "_irq"}, 32'(interrupt), 32'(pe.irq));
                chk({pe.nm, "_led"}, 32'(debug_led), 32'(pe.irq));
                chk({pe.nm, "_out"}, 32'(out), 32'(pe.outv));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] ev, input logic err, input string nm);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {24'h0, a}; PWDATA = d;
        tick();
        apb_q.push_back('{nm, ev, err});
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic err, input string nm);
        apb(1'b1, a, d, 32'h0, err, nm);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ev, input logic err, input string nm);
        apb(1'b0, a, 32'h0, ev, err, nm);
    endtask

    task automatic pin(input string nm, input int at, input logic irq, input logic [NOUT-1:0] o);
        pin_q.push_back('{nm, at, irq, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        pin("rst_pins", cyc, 1'b0, 2'b00);
        tick();
        PRESERN = 1'b1;
        tick();
        rd(8'h00, 32'h0, 1'b0, "rst_ctrl");
        rd(8'h08, 32'h0, 1'b0, "rst_pend");
        rd(8'h0C, 32'h0, 1'b0, "rst_status");
        rd(8'h20, 32'h0, 1'b0, "rst_cnt");

        // Rising edge on ch0: pending lands 2+DEB+1 cycles after src, irq one later
        wr(8'h00, 32'h1, 1'b0, "w_ctrl");
        wr(8'h04, 32'h1, 1'b0, "w_en");
        wr(8'h10, 32'h0, 1'b0, "w_mode");
        src[0] = 1'b1;
        t0 = cyc;
        pin("t1_w6", t0 + 6, 1'b0, 2'b00);
        pin("t1_w7", t0 + 7, 1'b0, 2'b11);
        pin("t1_w8", t0 + 8, 1'b1, 2'b11);
        tick(5);
        rd(8'h08, 32'h0, 1'b0, "t1_pend_early");
        rd(8'h08, 32'h1, 1'b0, "t1_pend_set");
        rd(8'h0C, 32'h1, 1'b0, "t1_status");
        rd(8'h20, 32'h1, 1'b0, "t1_cnt");

        // Glitch one cycle short of the debounce threshold
        src[1] = 1'b1;
        tick(DEB - 1);
        src[1] = 1'b0;
        tick(8);
        rd(8'h0C, 32'h1, 1'b0, "t2_status");
        rd(8'h08, 32'h1, 1'b0, "t2_pend");

        // W1C racing a level-mode set, then a real clear, then a falling edge
        wr(8'h10, 32'h3, 1'b0, "w_mode_lvl");
        wr(8'h08, 32'h1, 1'b0, "t3_w1c_race");
        rd(8'h08, 32'h1, 1'b0, "t3_pend_kept");
        rd(8'h20, 32'h1, 1'b0, "t3_cnt_same");
        wr(8'h10, 32'h0, 1'b0, "w_mode_rise");
        wr(8'h08, 32'h1, 1'b0, "t3_w1c");
        rd(8'h08, 32'h0, 1'b0, "t3_pend_clr");
        wr(8'h10, 32'h1, 1'b0, "w_mode_fall");
        src[0] = 1'b0;
        tick(10);
        rd(8'h08, 32'h1, 1'b0, "t3_fall_pend");
        rd(8'h20, 32'h2, 1'b0, "t3_fall_cnt");
        wr(8'h20, 32'h0, 1'b0, "t3_cnt_wclr");
        rd(8'h20, 32'h0, 1'b0, "t3_cnt_zero");
        wr(8'h08, 32'hF, 1'b0, "t3_w1c_all");
        rd(8'h08, 32'h0, 1'b0, "t3_pend_zero");

        // Output routing and software override
        wr(8'h14, 32'h32, 1'b0, "w_route");
        wr(8'h18, 32'h0, 1'b0, "w_omode0");
        src = 4'b0100;
        tick(10);
        pin("t4_ch2", cyc, 1'b0, 2'b01);
        src = 4'b1000;
        tick(10);
        pin("t4_ch3", cyc, 1'b0, 2'b10);
        src = 4'b0000;
        tick(10);
        pin("t4_none", cyc, 1'b0, 2'b00);
        wr(8'h18, 32'h2, 1'b0, "w_omode2");
        wr(8'h1C, 32'h2, 1'b0, "w_osw2");
        tick();
        pin("t4_sw", cyc, 1'b0, 2'b10);
        src = 4'b0100;
        tick(10);
        pin("t4_mix", cyc, 1'b0, 2'b11);
        rd(8'h0C, 32'h4, 1'b0, "t4_status");

        // Error responses and masked-width registers
        rd(8'h24, 32'h0, 1'b1, "t5_rd_bad");
        wr(8'h0C, 32'h0, 1'b1, "t5_wr_status");
        rd(8'h0C, 32'h4, 1'b0, "t5_status_kept");
        rd(8'h20, 32'h2, 1'b0, "t5_cnt");
        wr(8'h04, 32'hFFFF_FFFF, 1'b0, "w_en_all");
        rd(8'h04, 32'hF, 1'b0, "t5_en_masked");
        rd(8'h08, 32'hC, 1'b0, "t5_pend");
        pin("t5_irq", cyc, 1'b1, 2'b11);
        tick();

        // Reset landing in the middle of an access phase
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 32'h24; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        #1 PRESERN = 1'b0;
        #1;
        chk("t6_irq", 32'(interrupt), 32'd0);
        chk("t6_led", 32'(debug_led), 32'd0);
        chk("t6_out", 32'(out), 32'd0);
        chk("t6_pslverr", 32'(PSLVERR), 32'd0);
        chk("t6_prdata", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        src = '0;
        tick(2);
        PRESERN = 1'b1;
        tick();
        rd(8'h00, 32'h0, 1'b0, "t6_ctrl");
        rd(8'h04, 32'h0, 1'b0, "t6_en");
        rd(8'h08, 32'h0, 1'b0, "t6_pend");
        rd(8'h0C, 32'h0, 1'b0, "t6_status");
        rd(8'h10, 32'h0, 1'b0, "t6_mode");
        rd(8'h14, 32'h0, 1'b0, "t6_route");
        rd(8'h18, 32'h0, 1'b0, "t6_omode");
        rd(8'h1C, 32'h0, 1'b0, "t6_osw");
        rd(8'h20, 32'h0, 1'b0, "t6_cnt");
        pin("t6_pins", cyc, 1'b0, 2'b00);
        tick(2);

        for (int i = 0; i < 20 && (apb_q.size() + pin_q.size()) > 0; i++) tick();
        chk("queues_drained", 32'(apb_q.size() + pin_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
